// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and channel encoding for the demux_entrada input router.
package demux_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int STAT_W = 16;
    typedef enum logic {CH_A = 1'b0, CH_B = 1'b1} ch_e;
endpackage

// File: rtl/demux_fifo.sv
// demux_fifo: small synchronous FIFO with wrap-bit pointers; head reads 0 while empty.
module demux_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr, rd;
    logic [WIDTH-1:0] mem [DEPTH];
    // Same index with opposite wrap bits means the pointers are DEPTH apart.
    assign full  = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign empty = wr == rd;
    assign head  = empty ? '0 : mem[rd[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (push && !full) wr <= wr + (AW+1)'(1);
            if (pop && !empty) rd <= rd + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/demux_entrada.sv
// demux_entrada: routes one byte stream into two FIFO-backed channels by select or alternation.
// Optional per-channel accept counters when DEMUX_STATS_EN is defined.
module demux_entrada
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic             alt,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef DEMUX_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [STAT_W-1:0] a_count,
    output logic [STAT_W-1:0] b_count
`endif
);
    ch_e  tgt;
    logic tgl, acc, push_a, push_b, a_full, b_full, a_empty, b_empty;
    assign tgt      = ch_e'(alt ? tgl : sel);
    // Readiness looks only at stored state, never at the consumer ready inputs.
    assign in_ready = (tgt == CH_B) ? !b_full : !a_full;
    assign acc      = in_valid && in_ready;
    assign push_a   = acc && (tgt == CH_A);
    assign push_b   = acc && (tgt == CH_B);
    assign a_valid  = !a_empty;
    assign b_valid  = !b_empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tgl <= 1'b0;
        else if (acc && alt) tgl <= !tgl;
    end
    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .rst_n(rst_n), .push(push_a), .pop(a_ready), .din(in_data),
        .head(a_data), .full(a_full), .empty(a_empty)
    );
    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .rst_n(rst_n), .push(push_b), .pop(b_ready), .din(in_data),
        .head(b_data), .full(b_full), .empty(b_empty)
    );
`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count <= '0;
            b_count <= '0;
        end else if (stats_clr) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (push_a && a_count != '1) a_count <= a_count + STAT_W'(1);
            if (push_b && b_count != '1) b_count <= b_count + STAT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_demux_entrada.sv
// tb_demux_entrada: vector table plus queue scoreboard for demux_entrada.
module tb_demux_entrada;
    localparam int DEPTH = 2;
    logic clk, rst_n, in_valid, in_ready, sel, alt, a_valid, a_ready, b_valid, b_ready;
    logic [7:0] in_data, a_data, b_data;
`ifdef DEMUX_STATS_EN
    logic stats_clr;
    logic [15:0] a_count, b_count;
`endif
    int checks = 0, failures = 0;
    logic [7:0] qa[$], qb[$];
    logic mtgl;

    demux_entrada #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .alt(alt), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready)
`ifdef DEMUX_STATS_EN
        , .stats_clr(stats_clr), .a_count(a_count), .b_count(b_count)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic model_ready();
        logic t;
        t = alt ? mtgl : sel;
        return t ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
    endfunction

    // Scoreboard: accepted bytes are queued per channel, pops retire the head.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            mtgl = 0;
        end else begin
            logic acc, t;
            t = alt ? mtgl : sel;
            acc = in_valid && model_ready();
            if (a_ready && qa.size() != 0) void'(qa.pop_front());
            if (b_ready && qb.size() != 0) void'(qb.pop_front());
            if (acc) begin
                if (t) qb.push_back(in_data);
                else qa.push_back(in_data);
                if (alt) mtgl = !mtgl;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic s, input logic al,
                        input logic ar, input logic br);
        in_valid = v; in_data = d; sel = s; alt = al; a_ready = ar; b_ready = br;
        #1;
        chk("in_ready", in_ready, model_ready());
        chk("a_valid", a_valid, qa.size() != 0);
        chk("a_data", a_data, qa.size() != 0 ? qa[0] : 8'h00);
        chk("b_valid", b_valid, qb.size() != 0);
        chk("b_data", b_data, qb.size() != 0 ? qb[0] : 8'h00);
        @(negedge clk);
    endtask

    task automatic post(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd);
        chk("post_a_valid", a_valid, av);
        chk("post_a_data", a_data, ad);
        chk("post_b_valid", b_valid, bv);
        chk("post_b_data", b_data, bd);
    endtask

    typedef struct {
        logic v; logic [7:0] d; logic s, al, ar, br;
        logic av; logic [7:0] ad; logic bv; logic [7:0] bd;
    } vec_t;
    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1, 8'd10, 0, 0, 0, 0, 1, 8'd10, 0, 8'd0};
        tbl[1]  = '{1, 8'd20, 0, 0, 0, 0, 1, 8'd10, 0, 8'd0};
        tbl[2]  = '{0, 8'd0,  0, 0, 1, 0, 1, 8'd20, 0, 8'd0};
        tbl[3]  = '{0, 8'd0,  0, 0, 1, 0, 0, 8'd0,  0, 8'd0};
        tbl[4]  = '{1, 8'd1,  0, 1, 0, 0, 1, 8'd1,  0, 8'd0};
        tbl[5]  = '{1, 8'd2,  0, 1, 0, 0, 1, 8'd1,  1, 8'd2};
        tbl[6]  = '{1, 8'd3,  0, 1, 0, 0, 1, 8'd1,  1, 8'd2};
        tbl[7]  = '{1, 8'd4,  0, 1, 0, 0, 1, 8'd1,  1, 8'd2};
        tbl[8]  = '{0, 8'd0,  0, 1, 1, 1, 1, 8'd3,  1, 8'd4};
        tbl[9]  = '{0, 8'd0,  0, 1, 1, 1, 0, 8'd0,  0, 8'd0};
        tbl[10] = '{1, 8'd9,  1, 0, 0, 0, 0, 8'd0,  1, 8'd9};
        tbl[11] = '{1, 8'd5,  1, 1, 0, 0, 1, 8'd5,  1, 8'd9};
        tbl[12] = '{0, 8'd0,  0, 0, 1, 1, 0, 8'd0,  0, 8'd0};

        rst_n = 0; in_valid = 0; in_data = 0; sel = 0; alt = 0; a_ready = 0; b_ready = 0;
`ifdef DEMUX_STATS_EN
        stats_clr = 0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        post(0, 0, 0, 0);
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].al, tbl[i].ar, tbl[i].br);
            post(tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd);
        end

        // Backpressure on B: third byte waits for a freed slot.
        step(1, 8'd50, 1, 0, 0, 0);
        step(1, 8'd60, 1, 0, 0, 0);
        chk("b_full_ready", in_ready, 0);
        step(1, 8'd70, 1, 0, 0, 0);
        step(1, 8'd70, 1, 0, 0, 1);
        #1;
        chk("b_freed_ready", in_ready, 1);
        chk("b_head_60", b_data, 8'd60);
        step(1, 8'd70, 1, 0, 0, 0);
        step(0, 8'd0, 1, 0, 0, 1);
        chk("b_head_70", b_data, 8'd70);
        step(0, 8'd0, 1, 0, 0, 1);
        post(0, 0, 0, 0);

        // A full, held byte retargets to B by flipping sel.
        step(1, 8'd11, 0, 0, 0, 0);
        step(1, 8'd12, 0, 0, 0, 0);
        step(1, 8'd13, 0, 0, 0, 0);
        chk("a_full_ready", in_ready, 0);
        step(1, 8'd13, 1, 0, 0, 0);
        post(1, 8'd11, 1, 8'd13);
        step(0, 8'd0, 1, 0, 0, 0);

        // Asynchronous reset mid-stream clears FIFOs and tgl.
        #2;
        rst_n = 0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        post(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;
        step(1, 8'd77, 0, 1, 0, 0);
        post(1, 8'd77, 0, 0);
        step(0, 8'd0, 0, 0, 1, 0);

`ifdef DEMUX_STATS_EN
        stats_clr = 1;
        step(0, 8'd0, 0, 0, 1, 1);
        stats_clr = 0;
        step(1, 8'd31, 0, 0, 1, 1);
        step(1, 8'd32, 0, 0, 1, 1);
        step(1, 8'd33, 0, 0, 1, 1);
        step(1, 8'd34, 1, 0, 1, 1);
        chk("a_count", a_count, 3);
        chk("b_count", b_count, 1);
        stats_clr = 1;
        step(1, 8'd35, 0, 0, 1, 1);
        stats_clr = 0;
        chk("a_count_clr", a_count, 0);
        chk("b_count_clr", b_count, 0);
        step(0, 8'd0, 0, 0, 1, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux_entrada.md
Name: demux_entrada

Overview:
- Input-side counterpart of the output mux: takes one byte stream and routes each byte to one of two destination buses (A/B).
- Each destination has a small FIFO, so downstream consumers can stall independently.
- Routing is by explicit select or by automatic alternation.
- Sits between the sample source and the two processing paths whose results the output mux later recombines.

Parameters:
- WIDTH, 8, data bus width in bits
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  WIDTH  input byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept in_data this cycle
- sel  in  1  target channel when alt=0 (0=A, 1=B)
- alt  in  1  1 = alternate A/B per accepted byte, ignoring sel
- a_data  out  WIDTH  channel A head byte
- a_valid  out  1  channel A FIFO non-empty
- a_ready  in  1  channel A consumer accepts
- b_data  out  WIDTH  channel B head byte
- b_valid  out  1  channel B FIFO non-empty
- b_ready  in  1  channel B consumer accepts

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset:
  - Both FIFOs empty.
  - a_valid = b_valid = 0; a_data = b_data = 0.
  - Toggle register tgl = 0.
  - in_ready reflects the empty FIFOs, so it is 1 after reset.
- Target channel: tgt = alt ? tgl : sel (combinational).
- in_ready = !full(tgt). Depends only on registered FIFO state plus sel/alt/tgl; there is no path from a_ready/b_ready.
- Accept: in_valid && in_ready at a rising edge pushes in_data into FIFO tgt.
  - If alt=1, tgl flips on that edge.
  - tgl never changes without an accept.
- Latency: a byte accepted at edge N into an empty FIFO gives x_valid=1 and x_data=byte after edge N (visible in cycle N+1). There is no bypass path.
- Pop: x_valid && x_ready at an edge removes the head. x_data then shows the next entry, or 0 if the FIFO is now empty.
- Ordering: byte order is preserved within each channel. There is no ordering relation between channels.
- Full FIFO with a same-cycle pop on tgt: in_ready stays 0 that cycle. The freed slot becomes usable next cycle.
- Push and pop on the same non-empty, non-full FIFO in the same cycle: both occur and occupancy is unchanged.
- sel/alt may change while in_valid=1 and not yet accepted. Target is re-evaluated each cycle; the byte goes to whichever channel is targeted at the accepting edge.
- alt 1->0: tgl holds its value. alt 0->1: alternation resumes from the held tgl.
- Input side holds in_data/in_valid until accepted (valid/ready rule). The block never drops a byte.
- FIFO pointers: log2(DEPTH)+1 bits, wrapping naturally. full = (wr^rd) == DEPTH; empty = wr == rd.
- Reset asserted mid-operation: all FIFO contents discarded immediately and asynchronously; outputs go to reset values.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - Extra ports a_count and b_count, out, 16 bits each.
  - Each counts bytes accepted into its channel, saturating at 16'hFFFF.
  - Extra input stats_clr (1 bit): a synchronous clear to 0 that takes priority over an increment in the same cycle.
  - Counters are 0 on reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package demux_pkg:
  - Default WIDTH constant.
  - Channel enum CH_A=0, CH_B=1.
  - Counter width constant STAT_W=16.
- Sub-module demux_fifo (WIDTH, DEPTH): synchronous FIFO with push/pop/full/empty/head. Instantiated twice; routing logic and tgl stay in the top level.

Test Plan:
- Reset then sel=0, alt=0: push 10, 20 -> a_data=10 with a_valid after the first accept edge, then 20 after a pop; b_valid stays 0.
- sel=1, b_ready=0, DEPTH=2: push 50, 60, 70 -> in_ready drops after 60. Assert b_ready for one cycle -> in_ready returns the next cycle; 70 accepted; B order is 50, 60, 70.
- alt=1: push 1, 2, 3, 4 -> A receives 1, 3 and B receives 2, 4. Drop alt, then set alt=1 again -> next byte goes to A (tgl held at 0).
- A full and B empty, sel=0 with in_valid=1 held: switch sel to 1 -> byte accepted into B in that cycle.
- rst_n pulsed low mid-stream with both FIFOs partly filled -> a_valid = b_valid = 0 and a_data = b_data = 0 immediately; tgl=0.
- With DEMUX_STATS_EN: push 3 bytes to A and 1 to B -> a_count=3, b_count=1. Assert stats_clr during an accept -> count becomes 0.
